// File: rtl/req_ack_responder_if.sv
// req_ack_responder_if: request/acknowledge bus between a request source
// (master) and the req_ack_responder (slave), including its status outputs.
interface req_ack_responder_if #(
    parameter int CNT_W = 16
);
    logic             req;
    logic             ack;
    logic             busy;
    logic [3:0]       pend_cnt;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    modport master (
        output req,
        input  ack, busy, pend_cnt, txn_cnt, drop_cnt, overflow
    );

    modport slave (
        input  req,
        output ack, busy, pend_cnt, txn_cnt, drop_cnt, overflow
    );
endinterface

// File: rtl/req_ack_responder.sv
// req_ack_responder: samples req every cycle, queues up to MAX_PEND
// outstanding requests and returns one registered ack pulse per accepted
// request, ACK_DELAY cycles after it enters service. Drops are counted
// (saturating) and flagged in a sticky overflow bit; acks are counted (wrapping).
// Optional build macro: REQ_ACK_RESP_SVA_EN compiles in protocol assertions
// and a req->ack cover; functional logic is the same either way.
module req_ack_responder #(
    parameter int ACK_DELAY = 1,
    parameter int MAX_PEND  = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    req_ack_responder_if.slave  bus
);
    localparam logic [3:0] MAX_PEND_L = 4'(MAX_PEND);
    localparam logic [3:0] DLY_INIT   = 4'(ACK_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       dcnt;
    logic [3:0]       pend_cnt;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    logic             ack_i;
    logic             acc;
    logic             drop;
    logic             work;
    logic [3:0]       pend_nxt;

    // Saturating increment: the drop counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign ack_i = (state == ACK);

    // Accept when there is room, or when full but the head job retires this cycle.
    always_comb begin
        acc      = bus.req & ((pend_cnt < MAX_PEND_L) |
                              ((pend_cnt == MAX_PEND_L) & ack_i));
        drop     = bus.req & ~acc;
        pend_nxt = pend_cnt + 4'(acc) - 4'(ack_i);
        work     = (pend_nxt != 4'd0);
    end

    // Control FSM, occupancy and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dcnt     <= 4'd0;
            pend_cnt <= 4'd0;
            txn_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (ACK_DELAY == 1) state <= ACK;
                        else                state <= DELAY;
                        dcnt <= DLY_INIT;
                    end
                end
                DELAY: begin
                    dcnt <= dcnt - 4'd1;
                    if (dcnt == 4'd1) state <= ACK;
                end
                ACK: begin
                    txn_cnt <= txn_cnt + CNT_W'(1);
                    if (work) begin
                        // Next queued job starts its delay immediately.
                        if (ACK_DELAY == 1) state <= ACK;
                        else                state <= DELAY;
                        dcnt <= DLY_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack      = ack_i;
    assign bus.busy     = (state != IDLE);
    assign bus.pend_cnt = pend_cnt;
    assign bus.txn_cnt  = txn_cnt;
    assign bus.drop_cnt = drop_cnt;
    assign bus.overflow = overflow;

`ifdef REQ_ACK_RESP_SVA_EN
    a_ack_has_pend: assert property (@(posedge clk) disable iff (reset)
        ack_i |-> (pend_cnt != 4'd0));

    a_pend_bound: assert property (@(posedge clk) disable iff (reset)
        pend_cnt <= MAX_PEND_L);

    a_busy_iff_pend: assert property (@(posedge clk) disable iff (reset)
        (state != IDLE) == (pend_cnt != 4'd0));

    if (ACK_DELAY > 1) begin : g_ack_spacing
        a_no_b2b_ack: assert property (@(posedge clk) disable iff (reset)
            ack_i |=> !ack_i);
    end

    c_req_to_ack: cover property (@(posedge clk) disable iff (reset)
        ((state == IDLE) && bus.req) ##ACK_DELAY ack_i);
`else
`endif
endmodule

// File: tb/tb_req_ack_responder.sv
// tb_req_ack_responder: directed bench over five responder configurations.
// Stimulus pushes the expected ack (instance, cycle) into a scoreboard queue;
// a negedge monitor pops and compares whenever any instance raises ack.
module tb_req_ack_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0] rst_v;

    req_ack_responder_if #(.CNT_W(16)) bus_d1 ();
    req_ack_responder_if #(.CNT_W(16)) bus_d3 ();
    req_ack_responder_if #(.CNT_W(16)) bus_d4 ();
    req_ack_responder_if #(.CNT_W(4))  bus_dw ();
    req_ack_responder_if #(.CNT_W(4))  bus_ds ();

    req_ack_responder #(.ACK_DELAY(1), .MAX_PEND(4), .CNT_W(16)) dut_d1 (
        .clk(clk), .reset(rst_v[0]), .bus(bus_d1));
    req_ack_responder #(.ACK_DELAY(3), .MAX_PEND(4), .CNT_W(16)) dut_d3 (
        .clk(clk), .reset(rst_v[1]), .bus(bus_d3));
    req_ack_responder #(.ACK_DELAY(4), .MAX_PEND(4), .CNT_W(16)) dut_d4 (
        .clk(clk), .reset(rst_v[2]), .bus(bus_d4));
    req_ack_responder #(.ACK_DELAY(1), .MAX_PEND(4), .CNT_W(4)) dut_dw (
        .clk(clk), .reset(rst_v[3]), .bus(bus_dw));
    req_ack_responder #(.ACK_DELAY(15), .MAX_PEND(1), .CNT_W(4)) dut_ds (
        .clk(clk), .reset(rst_v[4]), .bus(bus_ds));

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [4:0] ack_v;
    assign ack_v = {bus_ds.ack, bus_dw.ack, bus_d4.ack, bus_d3.ack, bus_d1.ack};

    // Scoreboard monitor: every observed ack must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (ack_v[i] === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL ack_unexpected: dut %0d acked in cycle %0d, none expected", i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.id == i && e.cyc == cyc)
                        n_pass++;
                    else
                        $display("FAIL ack_timing: got dut %0d cycle %0d, expected dut %0d cycle %0d",
                                 i, cyc, e.id, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_ack(input int id, input int c);
        exp_t e;
        e.id  = id;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    int b;

    initial begin
        rst_v      = '1;
        bus_d1.req = 1'b0;
        bus_d3.req = 1'b0;
        bus_d4.req = 1'b0;
        bus_dw.req = 1'b0;
        bus_ds.req = 1'b0;

        // Reset in cycles 0-1; all outputs zero after the first reset edge.
        at(1);
        check("rst_d1", {bus_d1.ack, bus_d1.busy, bus_d1.overflow, bus_d1.pend_cnt, bus_d1.txn_cnt, bus_d1.drop_cnt}, 0);
        check("rst_d3", {bus_d3.ack, bus_d3.busy, bus_d3.overflow, bus_d3.pend_cnt, bus_d3.txn_cnt, bus_d3.drop_cnt}, 0);
        check("rst_d4", {bus_d4.ack, bus_d4.busy, bus_d4.overflow, bus_d4.pend_cnt, bus_d4.txn_cnt, bus_d4.drop_cnt}, 0);
        check("rst_dw", {bus_dw.ack, bus_dw.busy, bus_dw.overflow, bus_dw.pend_cnt, bus_dw.txn_cnt, bus_dw.drop_cnt}, 0);
        check("rst_ds", {bus_ds.ack, bus_ds.busy, bus_ds.overflow, bus_ds.pend_cnt, bus_ds.txn_cnt, bus_ds.drop_cnt}, 0);
        at(2);
        rst_v = '0;

        // Single pulse, ACK_DELAY=1: req cycle 3 -> ack cycle 4.
        at(3);
        bus_d1.req = 1'b1;
        expect_ack(0, 4);
        check("t1_busy_c3", bus_d1.busy, 0);
        at(4);
        bus_d1.req = 1'b0;
        check("t1_pend_c4", bus_d1.pend_cnt, 1);
        check("t1_busy_c4", bus_d1.busy, 1);
        at(5);
        check("t1_pend_c5", bus_d1.pend_cnt, 0);
        check("t1_busy_c5", bus_d1.busy, 0);
        check("t1_txn", bus_d1.txn_cnt, 1);

        // Streaming, ACK_DELAY=1: req held b+3..b+8 -> acks b+4..b+9.
        at(8);
        b = cyc;
        rst_v[0] = 1'b1;
        at(b + 1);
        rst_v[0] = 1'b0;
        check("t2_txn_after_rst", bus_d1.txn_cnt, 0);
        for (int k = 3; k <= 8; k++) begin
            at(b + k);
            bus_d1.req = 1'b1;
            expect_ack(0, b + k + 1);
            if (k >= 4) check("t2_pend_stream", bus_d1.pend_cnt, 1);
        end
        at(b + 9);
        bus_d1.req = 1'b0;
        check("t2_pend_c9", bus_d1.pend_cnt, 1);
        at(b + 10);
        check("t2_pend_end", bus_d1.pend_cnt, 0);
        check("t2_txn", bus_d1.txn_cnt, 6);
        check("t2_ovf", bus_d1.overflow, 0);

        // ACK_DELAY=3, pulses b+0..b+2 -> acks b+3, b+6, b+9.
        at(b + 14);
        b = cyc;
        bus_d3.req = 1'b1;
        expect_ack(1, b + 3);
        expect_ack(1, b + 6);
        expect_ack(1, b + 9);
        check("t3_busy_c0", bus_d3.busy, 0);
        at(b + 1);
        check("t3_busy_c1", bus_d3.busy, 1);
        at(b + 3);
        bus_d3.req = 1'b0;
        check("t3_pend_peak", bus_d3.pend_cnt, 3);
        at(b + 9);
        check("t3_busy_c9", bus_d3.busy, 1);
        at(b + 10);
        check("t3_busy_c10", bus_d3.busy, 0);
        check("t3_txn", bus_d3.txn_cnt, 3);

        // ACK_DELAY=3, reset in cycle 2 discards queued work: no acks.
        at(b + 12);
        b = cyc;
        bus_d3.req = 1'b1;
        at(b + 2);
        bus_d3.req = 1'b0;
        rst_v[1]   = 1'b1;
        at(b + 3);
        rst_v[1]   = 1'b0;
        check("t5_pend", bus_d3.pend_cnt, 0);
        check("t5_busy", bus_d3.busy, 0);
        check("t5_txn", bus_d3.txn_cnt, 0);
        at(b + 8);
        check("t5_busy_late", bus_d3.busy, 0);

        // ACK_DELAY=4, MAX_PEND=4, req held b+0..b+7: fill, accept-on-ack, drops.
        at(b + 10);
        b = cyc;
        bus_d4.req = 1'b1;
        for (int k = 0; k < 5; k++) expect_ack(2, b + 4 + 4 * k);
        at(b + 4);
        check("t4_pend_full", bus_d4.pend_cnt, 4);
        at(b + 5);
        check("t4_pend_acc_on_ack", bus_d4.pend_cnt, 4);
        check("t4_ovf_c5", bus_d4.overflow, 0);
        at(b + 6);
        check("t4_ovf_c6", bus_d4.overflow, 1);
        check("t4_drop_c6", bus_d4.drop_cnt, 1);
        at(b + 8);
        bus_d4.req = 1'b0;
        check("t4_drop", bus_d4.drop_cnt, 3);
        at(b + 21);
        check("t4_txn", bus_d4.txn_cnt, 5);
        check("t4_pend_end", bus_d4.pend_cnt, 0);
        check("t4_busy_end", bus_d4.busy, 0);
        check("t4_ovf_sticky", bus_d4.overflow, 1);

        // CNT_W=4, ACK_DELAY=1: 17 isolated pulses -> txn_cnt wraps to 1.
        at(b + 23);
        b = cyc;
        for (int i = 0; i < 17; i++) begin
            at(b + 3 * i);
            if (i == 15) check("t6_txn_allones", bus_dw.txn_cnt, 15);
            bus_dw.req = 1'b1;
            expect_ack(3, b + 3 * i + 1);
            at(b + 3 * i + 1);
            bus_dw.req = 1'b0;
        end
        at(b + 52);
        check("t6_txn_wrap", bus_dw.txn_cnt, 1);
        check("t6_drop", bus_dw.drop_cnt, 0);

        // ACK_DELAY=15, MAX_PEND=1, CNT_W=4: req held 20 cycles, drop_cnt saturates.
        at(b + 54);
        b = cyc;
        bus_ds.req = 1'b1;
        expect_ack(4, b + 15);
        expect_ack(4, b + 30);
        at(b + 1);
        check("t7_ovf_c1", bus_ds.overflow, 0);
        at(b + 2);
        check("t7_ovf_c2", bus_ds.overflow, 1);
        at(b + 15);
        check("t7_drop_c15", bus_ds.drop_cnt, 14);
        at(b + 16);
        check("t7_pend_c16", bus_ds.pend_cnt, 1);
        at(b + 20);
        bus_ds.req = 1'b0;
        check("t7_drop_sat", bus_ds.drop_cnt, 15);
        at(b + 31);
        check("t7_txn", bus_ds.txn_cnt, 2);
        check("t7_pend_end", bus_ds.pend_cnt, 0);
        check("t7_busy_end", bus_ds.busy, 0);

        // Every expected ack must have been seen, within a bounded wait.
        for (int w = 0; w < 40 && exp_q.size() != 0; w++) step();
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
